// File: rtl/detector_scheduler.sv
// -----------------------------------------------------------------------------
// detector_scheduler
//
// Round-robin front end that time-shares one serial Moore pattern detector
// between NREQ requesters. A job clears the detector, shifts the winning
// requester's WIDTH-bit word into it LSB-first, counts the cycles on which
// the detector flags a match, and reports the count with a one-cycle pulse.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : asynchronous reset, active low
//   req      : [NREQ] level request per requester
//   data     : [NREQ*WIDTH] job words, requester i owns bits [i*WIDTH +: WIDTH]
//   grant    : [NREQ] one-hot grant for the job in flight, zero when idle
//   det_rst  : active-high clear to the detector (also held while in reset)
//   det_w    : serial bit to the detector
//   det_z    : match flag from the detector
//   hits     : [HW] match count of the last completed job
//   done     : one-cycle pulse when hits is updated
// -----------------------------------------------------------------------------
module detector_scheduler #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int ZLAT  = 1,
  localparam int HW    = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         grant,
  output logic                    det_rst,
  output logic                    det_w,
  input  logic                    det_z,
  output logic [HW-1:0]           hits,
  output logic                    done
);

  localparam int IW = $clog2(NREQ);

  // Bit index limits; HW bits are wide enough to hold WIDTH itself, so
  // ZLAT == WIDTH is representable.
  localparam logic [HW-1:0] LAST_K     = HW'(WIDTH - 1);
  localparam logic [HW-1:0] ZLAT_K     = HW'(ZLAT);
  localparam logic [HW-1:0] DRAIN_LAST = HW'(ZLAT - 1);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [HW-1:0]   k;
  logic [HW-1:0]   cnt;
  logic [HW-1:0]   cnt_next;
  logic            clear_q;
  logic            count_en;
  logic            arb_hit;
  logic [IW-1:0]   arb_idx;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] nxt_bits;
  int              j;

  // Round-robin search: first set request at or above ptr, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!arb_hit && req[j]) begin
        arb_hit = 1'b1;
        arb_idx = IW'(j);
      end
    end
  end

  // The granted word is read live every shift cycle; det_w is registered,
  // so the bit for the next cycle is selected one edge ahead.
  assign word     = data[int'(gidx)*WIDTH +: WIDTH];
  assign nxt_bits = word >> (k + HW'(1));

  // The first ZLAT shift cycles still see the detector's response to the
  // cleared state; the DRAIN cycles pick up the tail, giving a window of
  // exactly WIDTH samples.
  assign count_en = ((state == S_SHIFT) && (k >= ZLAT_K)) || (state == S_DRAIN);
  assign cnt_next = cnt + HW'(count_en && det_z);

  assign det_rst = clear_q | ~reset;

  // Control stage: FSM, arbitration pointer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      k       <= '0;
      grant   <= '0;
      clear_q <= 1'b0;
      det_w   <= 1'b0;
      hits    <= '0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      clear_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_hit) begin
            gidx    <= arb_idx;
            grant   <= NREQ'(1) << arb_idx;
            clear_q <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          det_w <= word[0];
          k     <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (k == LAST_K) begin
            det_w <= 1'b0;
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            det_w <= nxt_bits[0];
            k     <= k + HW'(1);
          end
        end
        S_DRAIN: begin
          if (k == DRAIN_LAST) begin
            hits  <= cnt_next;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k <= k + HW'(1);
          end
        end
        S_DONE: begin
          ptr   <= (gidx == LAST_REQ) ? '0 : gidx + IW'(1);
          grant <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Count stage: hit accumulator, cleared at the start of every job
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      cnt <= '0;
    else if (count_en)
      cnt <= cnt_next;
  end

endmodule

// File: tb/tb_detector_scheduler.sv
module tb_detector_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ZLAT  = 1;
  localparam int HW    = $clog2(WIDTH + 1);

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       grant;
  logic                  det_rst;
  logic                  det_w;
  logic                  det_z;
  logic [HW-1:0]         hits;
  logic                  done;

  int checks   = 0;
  int failures = 0;
  int prev_hits = 0;

  detector_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .ZLAT(ZLAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .det_rst (det_rst),
    .det_w   (det_w),
    .det_z   (det_z),
    .hits    (hits),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector stand-in: det_z is det_w delayed by one cycle, cleared by det_rst.
  always_ff @(posedge clk) begin
    if (det_rst) det_z <= 1'b0;
    else         det_z <= det_w;
  end

  task automatic test_reset();
    reset = 1'b0;
    req   = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant actual=%b required=0000", grant); end
    checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL reset_det_rst actual=%b required=1", det_rst); end
    checks++; if (det_w !== 1'b0) begin failures++; $display("FAIL reset_det_w actual=%b required=0", det_w); end
    checks++; if (hits !== 4'd0) begin failures++; $display("FAIL reset_hits actual=%0d required=0", hits); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
    reset = 1'b1;
    #1;
    checks++; if (det_rst !== 1'b0) begin failures++; $display("FAIL release_det_rst actual=%b required=0", det_rst); end
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL idle_grant actual=%b required=0000", grant); end
    prev_hits = 0;
  endtask

  // Starts at a negedge while the DUT is idle; ends at the negedge of the
  // idle cycle that follows DONE (cycle 12).
  task automatic run_job(input logic [3:0] r, input logic [3:0] g, input logic [7:0] w,
                         input int exp_hits, input bit drop, input bit hold);
    int gi;
    gi = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
    data[gi*WIDTH +: WIDTH] = w;
    req = r;
    @(posedge clk);
    if (drop) begin #1; req = '0; end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      checks++; if (grant !== g) begin failures++; $display("FAIL grant c=%0d actual=%b required=%b", c, grant, g); end
      checks++; if (det_rst !== (c == 1)) begin failures++; $display("FAIL det_rst c=%0d actual=%b required=%b", c, det_rst, (c == 1)); end
      checks++; if (done !== (c == 11)) begin failures++; $display("FAIL done c=%0d actual=%b required=%b", c, done, (c == 11)); end
      if (c >= 2 && c <= 9) begin
        checks++; if (det_w !== w[c-2]) begin failures++; $display("FAIL det_w c=%0d actual=%b required=%b", c, det_w, w[c-2]); end
      end else begin
        checks++; if (det_w !== 1'b0) begin failures++; $display("FAIL det_w_idle c=%0d actual=%b required=0", c, det_w); end
      end
      if (c == 11) begin
        checks++; if (hits !== HW'(exp_hits)) begin failures++; $display("FAIL hits word=%h actual=%0d required=%0d", w, hits, exp_hits); end
      end else begin
        checks++; if (hits !== HW'(prev_hits)) begin failures++; $display("FAIL hits_hold c=%0d actual=%0d required=%0d", c, hits, prev_hits); end
      end
    end
    prev_hits = exp_hits;
    if (!hold) req = '0;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL gap_grant actual=%b required=0000", grant); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL gap_done actual=%b required=0", done); end
  endtask

  task automatic test_round_robin();
    run_job(4'b1111, 4'b0001, 8'h01, 1, 1'b0, 1'b1);
    run_job(4'b1111, 4'b0010, 8'h03, 2, 1'b0, 1'b1);
    run_job(4'b1111, 4'b0100, 8'h07, 3, 1'b0, 1'b1);
    run_job(4'b1111, 4'b1000, 8'hFF, 8, 1'b0, 1'b1);
    run_job(4'b1111, 4'b0001, 8'h01, 1, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    run_job(4'b0001, 4'b0001, 8'hA5, 4, 1'b0, 1'b0);
  endtask

  task automatic test_pointer_wrap();
    run_job(4'b1000, 4'b1000, 8'hFF, 8, 1'b0, 1'b0);
    run_job(4'b1001, 4'b0001, 8'hA5, 4, 1'b0, 1'b0);
    run_job(4'b1001, 4'b1000, 8'h81, 2, 1'b0, 1'b0);
  endtask

  task automatic test_request_drop();
    run_job(4'b0010, 4'b0010, 8'h03, 2, 1'b1, 1'b0);
  endtask

  task automatic test_extremes();
    run_job(4'b0100, 4'b0100, 8'h00, 0, 1'b0, 1'b0);
    run_job(4'b1000, 4'b1000, 8'hFF, 8, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    // Leave the pointer at 1 with a nonzero hit count before the abort.
    run_job(4'b0001, 4'b0001, 8'h0F, 4, 1'b0, 1'b0);
    data[1*WIDTH +: WIDTH] = 8'h0F;
    req = 4'b0010;
    @(posedge clk);
    #1 req = '0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL midrst_grant actual=%b required=0000", grant); end
    checks++; if (det_w !== 1'b0) begin failures++; $display("FAIL midrst_det_w actual=%b required=0", det_w); end
    checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL midrst_det_rst actual=%b required=1", det_rst); end
    checks++; if (hits !== 4'd0) begin failures++; $display("FAIL midrst_hits actual=%0d required=0", hits); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done actual=%b required=0", done); end
      checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL midrst_hold_det_rst actual=%b required=1", det_rst); end
    end
    reset = 1'b1;
    prev_hits = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL post_rst_done actual=%b required=0", done); end
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL post_rst_grant actual=%b required=0000", grant); end
    end
    // Pointer back at 0: 0101 must pick requester 0, not 2.
    run_job(4'b0101, 4'b0001, 8'h33, 4, 1'b0, 1'b0);
    run_job(4'b0100, 4'b0100, 8'h80, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_pointer_wrap();
    test_request_drop();
    test_extremes();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
